wb_stage_multi: RTL and testbench
=================================

// Module: wb_stage_multi
// PURPOSE
//  Multi-lane write-back stage: last pipeline stage after MEM. Latches a group of up to LANES retiring
//  instructions, writes the register file with byte enables, and drives per-lane stall/forward info to ID
//  and the difftest trace. Optional serial-trace mode retires one lane per cycle.
// PARAMETERS
//  LANES  2   lanes per group (1..4); lane 0 = oldest
//  DW     32  result/GPR width (multiple of 8); BW = DW/8 byte enables
//  AW     5   GPR index width; dest 0 is never written
//  PCW    32  PC width; LW = BW+AW+DW+PCW bits per lane
// PORTS
//  clk                  in   1          clock
//  resetn               in   1          async active-low reset
//  ws_allowin           out  1          WS accepts a new group this cycle
//  ms_to_ws_valid       in   1          MS offers a group
//  ms_to_ws_lane_valid  in   LANES      per-lane valid within group
//  ms_to_ws_bus         in   LANES*LW   lane i at [i*LW+:LW] = {gr_we[BW],dest[AW],result[DW],pc[PCW]}
//  ws_to_rf_we          out  LANES*BW   per-port byte write enables
//  ws_to_rf_waddr       out  LANES*AW   per-port write index
//  ws_to_rf_wdata       out  LANES*DW   per-port write data
//  stall_ws_bus         out  LANES*(1+AW) per lane {pending_write, dest}
//  forward_ws_bus       out  LANES*(1+DW) per lane {fwd_valid, result}
//  debug_wb_pc          out  TW*PCW     TW = LANES, or 1 with WB_SERIAL_TRACE_EN
//  debug_wb_rf_wen      out  TW*BW      trace byte enables
//  debug_wb_rf_wnum     out  TW*AW      trace dest
//  debug_wb_rf_wdata    out  TW*DW      trace data
// BEHAVIOUR
//  - Reset (async, resetn=0): ws_valid=0, lane-valid reg=0, group reg=0, idx=0. Outputs: ws_allowin=1,
//    all rf_we/debug_wen=0, stall/forward valid bits=0, debug pc/wnum/wdata=0. Release mid-group drops the group.
//  - Handshake: ws_allowin = !ws_valid | ws_ready_go. On ms_to_ws_valid & ws_allowin: capture bus and lane
//    valids, ws_valid<=1, idx<=0; else if ws_allowin: ws_valid<=0. Bus reg holds when not captured.
//  - Effective lane valid: lv[i] = ws_valid & lane_valid_r[i] & lane_valid_r[j] for all j<i
//    (lanes after the first invalid lane ignored). Group with no valid lane: retires in 1 cycle, no writes.
//  - Write enable per lane: we[i] = gr_we[i] & {BW{lv[i] & dest[i]!=0}}.
//  - Parallel mode (macro undefined): ws_ready_go=1, latency 1 cycle, all lanes write in the capture+1 cycle.
//    Same-dest merge: lane i bytes also written by a younger lane k>i to same dest are cleared in lane i's
//    port and its trace wen (younger wins per byte). Port i waddr=dest[i], wdata=result[i].
//  - stall_ws_bus[i] = {|we[i], dest[i]}; forward_ws_bus[i] = {lv[i], result[i]}.
//  - Debug (parallel): slot i = {pc[i], we[i], dest[i], result[i]}; wen=0 for invalid lanes.
// CONFIGURATION
//  WB_SERIAL_TRACE_EN defined: TW=1; one lane retires per cycle. Counter idx (clog2(LANES) bits) selects
//    lane; only port idx has we (others 0); trace shows lane idx. Lanes beyond last valid are skipped:
//    ws_ready_go = (idx == last valid lane) | no valid lane; else idx<=idx+1 and WS stalls (ws_allowin=0).
//    No same-dest merge (program order holds). Stall/forward for lanes < idx have pending/valid=0.
//    Group of k valid lanes occupies k cycles; back-to-back groups have no bubble.
//  Undefined: parallel mode above, TW=LANES.
// TESTING
//  1. Reset mid-group, resetn=0 -> ws_allowin=1, all rf_we=0, debug_wen=0 same cycle, group lost.
//  2. Parallel, lane0 {we=F,d=3,r=0x11111111}, lane1 {we=3,d=3,r=0x2222_2222} -> port0 we=C, port1 we=3, 1 cycle.
//  3. Parallel, lane0 dest=0 we=F, lane1 valid=0 -> no rf write, trace wen=0, stall pending=0.
//  4. Serial, 2 valid lanes (pc 0x100,0x104), MS valid held -> ws_allowin=0 cycle1 (trace 0x100),
//     =1 cycle2 (trace 0x104), next group captured cycle3.
//  5. Serial, lane_valid=2'b10 -> lane1 ignored, zero-write 1-cycle retire, ws_allowin stays 1.

Source files
------------

// File: rtl/wb_stage_multi.sv
// wb_stage_multi: multi-lane write-back stage with byte-enabled RF ports, stall/forward info and difftest trace.
// Optional feature macro WB_SERIAL_TRACE_EN: retire one lane per cycle with a single trace slot.
module wb_stage_multi #(
    parameter int LANES = 2,
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int PCW   = 32,
    localparam int BW   = DW / 8,
    localparam int LW   = BW + AW + DW + PCW,
`ifdef WB_SERIAL_TRACE_EN
    localparam int TW   = 1
`else
    localparam int TW   = LANES
`endif
) (
    input  logic                    clk,
    input  logic                    resetn,
    output logic                    ws_allowin,
    input  logic                    ms_to_ws_valid,
    input  logic [LANES-1:0]        ms_to_ws_lane_valid,
    input  logic [LANES*LW-1:0]     ms_to_ws_bus,
    output logic [LANES*BW-1:0]     ws_to_rf_we,
    output logic [LANES*AW-1:0]     ws_to_rf_waddr,
    output logic [LANES*DW-1:0]     ws_to_rf_wdata,
    output logic [LANES*(1+AW)-1:0] stall_ws_bus,
    output logic [LANES*(1+DW)-1:0] forward_ws_bus,
    output logic [TW*PCW-1:0]       debug_wb_pc,
    output logic [TW*BW-1:0]        debug_wb_rf_wen,
    output logic [TW*AW-1:0]        debug_wb_rf_wnum,
    output logic [TW*DW-1:0]        debug_wb_rf_wdata
);
    logic                        ws_valid, ws_ready_go, run;
    logic [LANES-1:0]            lane_valid_r, lv;
    logic [LANES*LW-1:0]         bus_r;
    logic [LANES-1:0][BW-1:0]    gr_we, we, pw;
    logic [LANES-1:0][AW-1:0]    dest;
    logic [LANES-1:0][DW-1:0]    result;
    logic [LANES-1:0][PCW-1:0]   pc;
    logic [LANES-1:0]            live;

    assign ws_allowin = !ws_valid || ws_ready_go;

    // unpack lanes; a lane is effective only if it and every older lane are valid
    always_comb begin
        run = ws_valid;
        for (int i = 0; i < LANES; i++) begin
            {gr_we[i], dest[i], result[i], pc[i]} = bus_r[i*LW +: LW];
            run   = run & lane_valid_r[i];
            lv[i] = run;
            we[i] = gr_we[i] & {BW{lv[i] && (dest[i] != '0)}};
        end
    end

`ifdef WB_SERIAL_TRACE_EN
    localparam int IW = LANES > 1 ? $clog2(LANES) : 1;
    logic [IW-1:0] idx, last;

    // one lane per cycle: only port idx writes, lanes already retired report nothing
    always_comb begin
        last = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lv[i]) last = IW'(i);
            live[i] = IW'(i) >= idx;
            pw[i]   = (IW'(i) == idx) ? we[i] : '0;
        end
        ws_ready_go       = !(|lv) || (idx == last);
        debug_wb_pc       = pc[idx];
        debug_wb_rf_wen   = we[idx];
        debug_wb_rf_wnum  = dest[idx];
        debug_wb_rf_wdata = result[idx];
    end

    // lane cursor restarts on capture and advances while the group is still retiring
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                           idx <= '0;
        else if (ms_to_ws_valid && ws_allowin) idx <= '0;
        else if (ws_valid && !ws_ready_go)     idx <= idx + 1'b1;
    end
`else
    // whole group retires at once; a younger lane to the same dest wins each byte
    always_comb begin
        ws_ready_go = 1'b1;
        live        = '1;
        pw          = we;
        for (int i = 0; i < LANES; i++) begin
            for (int k = i + 1; k < LANES; k++)
                if (dest[k] == dest[i]) pw[i] = pw[i] & ~we[k];
            debug_wb_pc[i*PCW +: PCW]      = pc[i];
            debug_wb_rf_wen[i*BW +: BW]    = pw[i];
            debug_wb_rf_wnum[i*AW +: AW]   = dest[i];
            debug_wb_rf_wdata[i*DW +: DW]  = result[i];
        end
    end
`endif

    // per-port register file writes and per-lane hazard info for ID
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            ws_to_rf_we[i*BW +: BW]           = pw[i];
            ws_to_rf_waddr[i*AW +: AW]        = dest[i];
            ws_to_rf_wdata[i*DW +: DW]        = result[i];
            stall_ws_bus[i*(1+AW) +: 1+AW]    = {(|we[i]) && live[i], dest[i]};
            forward_ws_bus[i*(1+DW) +: 1+DW]  = {lv[i] && live[i], result[i]};
        end
    end

    // group register: capture on handshake, drop valid once retired with nothing new
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_valid     <= 1'b0;
            lane_valid_r <= '0;
            bus_r        <= '0;
        end else if (ms_to_ws_valid && ws_allowin) begin
            ws_valid     <= 1'b1;
            lane_valid_r <= ms_to_ws_lane_valid;
            bus_r        <= ms_to_ws_bus;
        end else if (ws_allowin) begin
            ws_valid     <= 1'b0;
        end
    end
endmodule

// File: tb/tb_wb_stage_multi.sv
// tb_wb_stage_multi: directed checks of wb_stage_multi (LANES=2, DW=32, AW=5, PCW=32).
module tb_wb_stage_multi;
    localparam int LANES = 2, DW = 32, AW = 5, PCW = 32, BW = 4, LW = BW + AW + DW + PCW;
`ifdef WB_SERIAL_TRACE_EN
    localparam int TW = 1;
`else
    localparam int TW = LANES;
`endif

    logic                    clk = 1'b0;
    logic                    resetn = 1'b0;
    logic                    ws_allowin;
    logic                    ms_to_ws_valid = 1'b0;
    logic [LANES-1:0]        ms_to_ws_lane_valid = '0;
    logic [LANES*LW-1:0]     ms_to_ws_bus = '0;
    logic [LANES*BW-1:0]     ws_to_rf_we;
    logic [LANES*AW-1:0]     ws_to_rf_waddr;
    logic [LANES*DW-1:0]     ws_to_rf_wdata;
    logic [LANES*(1+AW)-1:0] stall_ws_bus;
    logic [LANES*(1+DW)-1:0] forward_ws_bus;
    logic [TW*PCW-1:0]       debug_wb_pc;
    logic [TW*BW-1:0]        debug_wb_rf_wen;
    logic [TW*AW-1:0]        debug_wb_rf_wnum;
    logic [TW*DW-1:0]        debug_wb_rf_wdata;
    int total = 0, bad = 0;

    wb_stage_multi dut (
        .clk(clk), .resetn(resetn), .ws_allowin(ws_allowin),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_lane_valid(ms_to_ws_lane_valid),
        .ms_to_ws_bus(ms_to_ws_bus), .ws_to_rf_we(ws_to_rf_we), .ws_to_rf_waddr(ws_to_rf_waddr),
        .ws_to_rf_wdata(ws_to_rf_wdata), .stall_ws_bus(stall_ws_bus), .forward_ws_bus(forward_ws_bus),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] ln(input logic [3:0] w, input logic [4:0] d,
                                         input logic [31:0] r, input logic [31:0] p);
        return {w, d, r, p};
    endfunction

    initial begin
        tick;
        chk("rst_allowin", 64'(ws_allowin), 64'h1);
        chk("rst_rf_we", 64'(ws_to_rf_we), 64'h0);
        chk("rst_dbg_wen", 64'(debug_wb_rf_wen), 64'h0);
        chk("rst_dbg_pc", 64'(debug_wb_pc), 64'h0);
        chk("rst_stall_fwd", {62'h0, stall_ws_bus[11], forward_ws_bus[65]}, 64'h0);
        resetn = 1'b1;
        tick;
        chk("idle_allowin", 64'(ws_allowin), 64'h1);

        // reset asserted while a group is held drops it immediately
        ms_to_ws_valid = 1'b1; ms_to_ws_lane_valid = 2'b01;
        ms_to_ws_bus = {ln(4'hF, 5'd9, 32'h9, 32'h44), ln(4'hF, 5'd5, 32'h55, 32'h40)};
        tick;
        ms_to_ws_valid = 1'b0;
        chk("mid_rf_we_before", 64'(ws_to_rf_we), 64'h0F);
        resetn = 1'b0;
        #1;
        chk("mid_rst_allowin", 64'(ws_allowin), 64'h1);
        chk("mid_rst_rf_we", 64'(ws_to_rf_we), 64'h0);
        chk("mid_rst_dbg_wen", 64'(debug_wb_rf_wen), 64'h0);
        tick;
        resetn = 1'b1;
        tick;
        chk("mid_rst_lost", 64'(ws_to_rf_we), 64'h0);

`ifdef WB_SERIAL_TRACE_EN
        // two valid lanes, MS keeps offering: stall one cycle then accept
        ms_to_ws_valid = 1'b1; ms_to_ws_lane_valid = 2'b11;
        ms_to_ws_bus = {ln(4'hF, 5'd2, 32'hBB, 32'h104), ln(4'hF, 5'd1, 32'hAA, 32'h100)};
        tick;
        chk("ser_c1_allowin", 64'(ws_allowin), 64'h0);
        chk("ser_c1_pc", 64'(debug_wb_pc), 64'h100);
        chk("ser_c1_rf_we", 64'(ws_to_rf_we), 64'h0F);
        chk("ser_c1_dbg_wen", 64'(debug_wb_rf_wen), 64'hF);
        tick;
        chk("ser_c2_allowin", 64'(ws_allowin), 64'h1);
        chk("ser_c2_pc", 64'(debug_wb_pc), 64'h104);
        chk("ser_c2_rf_we", 64'(ws_to_rf_we), 64'hF0);
        chk("ser_c2_wdata", 64'(debug_wb_rf_wdata), 64'hBB);
        chk("ser_c2_lane0_pend", 64'(stall_ws_bus[5]), 64'h0);
        ms_to_ws_lane_valid = 2'b10;
        ms_to_ws_bus = {ln(4'hF, 5'd7, 32'hDD, 32'h204), ln(4'hF, 5'd6, 32'hCC, 32'h200)};
        tick;
        ms_to_ws_valid = 1'b0;
        chk("ser_c3_pc", 64'(debug_wb_pc), 64'h200);
        chk("ser_c3_rf_we", 64'(ws_to_rf_we), 64'h0);
        chk("ser_c3_dbg_wen", 64'(debug_wb_rf_wen), 64'h0);
        chk("ser_c3_allowin", 64'(ws_allowin), 64'h1);
        tick;
        chk("ser_c4_allowin", 64'(ws_allowin), 64'h1);
`else
        // same dest, younger lane wins its bytes
        ms_to_ws_valid = 1'b1; ms_to_ws_lane_valid = 2'b11;
        ms_to_ws_bus = {ln(4'h3, 5'd3, 32'h22222222, 32'h104), ln(4'hF, 5'd3, 32'h11111111, 32'h100)};
        tick;
        ms_to_ws_valid = 1'b0;
        chk("t2_rf_we", 64'(ws_to_rf_we), 64'h3C);
        chk("t2_waddr", 64'(ws_to_rf_waddr), 64'h63);
        chk("t2_wdata", 64'(ws_to_rf_wdata), 64'h22222222_11111111);
        chk("t2_dbg_wen", 64'(debug_wb_rf_wen), 64'h3C);
        chk("t2_dbg_pc", 64'(debug_wb_pc), 64'h00000104_00000100);
        chk("t2_stall", 64'(stall_ws_bus), 64'h8E3);
        chk("t2_fwd_v", {62'h0, forward_ws_bus[65], forward_ws_bus[32]}, 64'h3);
        chk("t2_allowin", 64'(ws_allowin), 64'h1);
        tick;
        chk("t2_retired_we", 64'(ws_to_rf_we), 64'h0);
        chk("t2_retired_fwd", {62'h0, forward_ws_bus[65], forward_ws_bus[32]}, 64'h0);

        // dest 0 never written, second lane invalid
        ms_to_ws_valid = 1'b1; ms_to_ws_lane_valid = 2'b01;
        ms_to_ws_bus = {ln(4'hF, 5'd7, 32'h12345678, 32'h204), ln(4'hF, 5'd0, 32'hDEADBEEF, 32'h200)};
        tick;
        ms_to_ws_valid = 1'b0;
        chk("t3_rf_we", 64'(ws_to_rf_we), 64'h0);
        chk("t3_dbg_wen", 64'(debug_wb_rf_wen), 64'h0);
        chk("t3_pend", {62'h0, stall_ws_bus[11], stall_ws_bus[5]}, 64'h0);
        chk("t3_fwd_v", {62'h0, forward_ws_bus[65], forward_ws_bus[32]}, 64'h1);

        // lane after an invalid lane is ignored
        ms_to_ws_valid = 1'b1; ms_to_ws_lane_valid = 2'b10;
        ms_to_ws_bus = {ln(4'hF, 5'd9, 32'h9, 32'h304), ln(4'hF, 5'd4, 32'h4, 32'h300)};
        tick;
        chk("t4_rf_we", 64'(ws_to_rf_we), 64'h0);
        chk("t4_fwd_v", {62'h0, forward_ws_bus[65], forward_ws_bus[32]}, 64'h0);
        chk("t4_allowin", 64'(ws_allowin), 64'h1);

        // back-to-back groups, distinct then shared dest
        ms_to_ws_lane_valid = 2'b11;
        ms_to_ws_bus = {ln(4'hF, 5'd2, 32'h02, 32'h404), ln(4'hF, 5'd1, 32'h01, 32'h400)};
        tick;
        chk("b2b_g1_we", 64'(ws_to_rf_we), 64'hFF);
        ms_to_ws_bus = {ln(4'hF, 5'd6, 32'h06, 32'h504), ln(4'h3, 5'd6, 32'h05, 32'h500)};
        tick;
        ms_to_ws_valid = 1'b0;
        chk("b2b_g2_we", 64'(ws_to_rf_we), 64'hF0);
        chk("b2b_g2_waddr", 64'(ws_to_rf_waddr), 64'hC6);
        chk("b2b_g2_dbg_pc", 64'(debug_wb_pc), 64'h00000504_00000500);
        chk("b2b_g2_stall", 64'(stall_ws_bus), 64'h9A6);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
